// File: rtl/exec_queue_param_if.sv
// Push/pop/flush bundle for exec_queue_param.
// The master drives the requests and write data; the slave (the queue) drives head data and status.
interface exec_queue_param_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_wr_en;
  logic                  i_rd_en;
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_almost_full;
  logic [CW-1:0]         o_count;
  logic                  o_ovf_err;
  logic                  o_udf_err;

  modport master (
    output i_data, i_wr_en, i_rd_en, i_flush,
    input  o_data, o_valid, o_empty, o_full, o_almost_full, o_count, o_ovf_err, o_udf_err
  );

  modport slave (
    input  i_data, i_wr_en, i_rd_en, i_flush,
    output o_data, o_valid, o_empty, o_full, o_almost_full, o_count, o_ovf_err, o_udf_err
  );
endinterface

// File: rtl/exec_queue_param.sv
// First-word-fall-through execution queue with wrap-bit pointers, flush and sticky error flags.
// Optional empty-queue bypass is enabled by defining EXEC_QUEUE_BYPASS_EN.
module exec_queue_param #(
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = 128,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  exec_queue_param_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wp_r;
  logic [PW-1:0]         rp_r;
  logic                  ovf_r;
  logic                  udf_r;

  logic                  empty_s;
  logic                  full_s;
  logic [PW-1:0]         count_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  byp_s;
  logic                  wr_fire_s;
  logic                  ovf_set_s;
  logic                  udf_set_s;

  assign empty_s = (wp_r == rp_r);
  assign full_s  = (wp_r[AW-1:0] == rp_r[AW-1:0]) && (wp_r[AW] != rp_r[AW]);
  assign count_s = wp_r - rp_r;

`ifdef EXEC_QUEUE_BYPASS_EN
  assign byp_s = empty_s & bus.i_wr_en & bus.i_rd_en & ~bus.i_flush;
`else
  assign byp_s = 1'b0;
`endif

  // A pop frees a slot in the same cycle, so a push while full is legal when paired with a pop.
  assign pop_s     = bus.i_rd_en & ~empty_s;
  assign push_s    = bus.i_wr_en & (~full_s | pop_s);
  assign wr_fire_s = push_s & ~byp_s & ~bus.i_flush;
  assign ovf_set_s = bus.i_wr_en & full_s & ~pop_s & ~bus.i_flush;
  assign udf_set_s = bus.i_rd_en & empty_s & ~byp_s & ~bus.i_flush;

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_r <= {PW{1'b0}};
      rp_r <= {PW{1'b0}};
    end else if (bus.i_flush) begin
      wp_r <= {PW{1'b0}};
      rp_r <= {PW{1'b0}};
    end else begin
      if (wr_fire_s) wp_r <= wp_r + ONE_C;
      if (pop_s)     rp_r <= rp_r + ONE_C;
    end
  end

  // Storage array; contents are never cleared, pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (wr_fire_s) mem_r[wp_r[AW-1:0]] <= bus.i_data;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_set_s) ovf_r <= 1'b1;
      if (udf_set_s) udf_r <= 1'b1;
    end
  end

  // Head presentation: bypassed write data, stored head, or zero when empty.
  always_comb begin
    bus.o_data  = {DATA_WIDTH{1'b0}};
    bus.o_valid = 1'b0;
    if (byp_s) begin
      bus.o_data  = bus.i_data;
      bus.o_valid = 1'b1;
    end else if (!empty_s) begin
      bus.o_data  = mem_r[rp_r[AW-1:0]];
      bus.o_valid = 1'b1;
    end else begin
      bus.o_data  = {DATA_WIDTH{1'b0}};
      bus.o_valid = 1'b0;
    end
  end

  assign bus.o_empty       = empty_s;
  assign bus.o_full        = full_s;
  assign bus.o_count       = count_s;
  assign bus.o_almost_full = (count_s >= AFULL_C);
  assign bus.o_ovf_err     = ovf_r;
  assign bus.o_udf_err     = udf_r;
endmodule
